// File: rtl/irq_pkg.sv
// Shared types and constants for the machine-mode interrupt sequencer and the CSR file.
package irq_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      TAKE    = 2'd2,
      HANDLER = 2'd3
   } irq_state_t;

   localparam int N_SRC_DEFAULT = 4;

   // Interrupt flag the CSR file ORs into MCAUSE when it composes cause values.
   localparam logic [31:0] MCAUSE_INT_BIT = 32'h8000_0000;

endpackage

// File: rtl/irq_sequencer_if.sv
// Bundle between the interrupt sequencer and its environment (IRQ lines, CPU FSM, CSR file).
// Handshake: int_req is level "take me at a boundary"; the take happens on the clock edge where
// int_req and instr_boundary are both high, and int_taken is the one-cycle acknowledgement after it.
interface irq_sequencer_if
   import irq_pkg::*;
#(
   parameter int N_SRC   = N_SRC_DEFAULT,
   parameter int CAUSE_W = $clog2(N_SRC)
);
   logic [N_SRC-1:0]   irq;
   logic               csr_mie;
   logic               instr_boundary;
   logic               mret;
   logic               int_req;
   logic               int_taken;
   logic [CAUSE_W-1:0] int_cause;
   logic               in_handler;
   logic [N_SRC-1:0]   pending;
   irq_state_t         dbg_state;

   modport master (
      output irq, csr_mie, instr_boundary, mret,
      input  int_req, int_taken, int_cause, in_handler, pending, dbg_state
   );

   modport slave (
      input  irq, csr_mie, instr_boundary, mret,
      output int_req, int_taken, int_cause, in_handler, pending, dbg_state
   );

endinterface

// File: rtl/irq_sequencer_arbiter.sv
// Combinational grant selection over the pending vector.
// IRQ_SEQ_RR_EN selects round-robin starting at i_ptr; otherwise fixed lowest-index priority.
module irq_arbiter
   import irq_pkg::*;
#(
   parameter int N_SRC   = N_SRC_DEFAULT,
   parameter int CAUSE_W = $clog2(N_SRC)
) (
   input  logic [N_SRC-1:0]   i_pending,
`ifdef IRQ_SEQ_RR_EN
   input  logic [CAUSE_W-1:0] i_ptr,
`endif
   output logic [CAUSE_W-1:0] o_grant,
   output logic               o_valid
);

`ifdef IRQ_SEQ_RR_EN
   int w_idx;

   // Scan offsets from farthest to nearest so the first set bit at/after the pointer wins.
   always_comb begin
      o_grant = '0;
      o_valid = 1'b0;
      w_idx   = 0;
      for (int k = N_SRC - 1; k >= 0; k--) begin
         w_idx = (int'(i_ptr) + k) % N_SRC;
         if (i_pending[w_idx]) begin
            o_grant = CAUSE_W'(w_idx);
            o_valid = 1'b1;
         end
      end
   end
`else
   always_comb begin
      o_grant = '0;
      o_valid = 1'b0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (i_pending[i]) begin
            o_grant = CAUSE_W'(i);
            o_valid = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/irq_sequencer.sv
// Machine-mode interrupt sequencer: edge-latches IRQ lines, arbitrates, hands off to the CPU at an
// instruction boundary and blocks nesting until MRET. Optional macro IRQ_SEQ_RR_EN: round-robin grant.
module irq_sequencer
   import irq_pkg::*;
#(
   parameter int N_SRC   = N_SRC_DEFAULT,
   parameter int CAUSE_W = $clog2(N_SRC)
) (
   input logic            i_clk,
   input logic            i_rst_n,
   irq_sequencer_if.slave io_seq
);

   irq_state_t         r_state;
   irq_state_t         w_state_nxt;
   logic [N_SRC-1:0]   r_irq_q;
   logic [N_SRC-1:0]   r_pending;
   logic [N_SRC-1:0]   w_edge;
   logic [N_SRC-1:0]   w_clear;
   logic [CAUSE_W-1:0] r_cause;
   logic [CAUSE_W-1:0] w_grant;
   logic               w_grant_valid;
   logic               w_take;

`ifdef IRQ_SEQ_RR_EN
   logic [CAUSE_W-1:0] r_ptr;

   irq_arbiter #(.N_SRC(N_SRC), .CAUSE_W(CAUSE_W)) u_arbiter (
      .i_pending (r_pending),
      .i_ptr     (r_ptr),
      .o_grant   (w_grant),
      .o_valid   (w_grant_valid)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ptr <= '0;
      end else if (w_take) begin
         if (int'(w_grant) == N_SRC - 1) r_ptr <= '0;
         else                            r_ptr <= w_grant + 1'b1;
      end
   end
`else
   irq_arbiter #(.N_SRC(N_SRC), .CAUSE_W(CAUSE_W)) u_arbiter (
      .i_pending (r_pending),
      .o_grant   (w_grant),
      .o_valid   (w_grant_valid)
   );
`endif

   assign w_edge  = io_seq.irq & ~r_irq_q;
   assign w_take  = (r_state == ARMED) && io_seq.csr_mie && w_grant_valid && io_seq.instr_boundary;
   assign w_clear = w_take ? (N_SRC'(1) << w_grant) : '0;

   // A new edge on the bit being taken is ORed in after the clear, so it stays pending.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_irq_q   <= '0;
         r_pending <= '0;
         r_cause   <= '0;
      end else begin
         r_irq_q   <= io_seq.irq;
         r_pending <= (r_pending & ~w_clear) | w_edge;
         if (w_take) r_cause <= w_grant;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (w_grant_valid && io_seq.csr_mie) w_state_nxt = ARMED;
         ARMED: begin
            if (!io_seq.csr_mie || !w_grant_valid) w_state_nxt = IDLE;
            else if (io_seq.instr_boundary)        w_state_nxt = TAKE;
         end
         TAKE:    w_state_nxt = HANDLER;
         HANDLER: if (io_seq.mret) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      io_seq.int_req    = (r_state == ARMED);
      io_seq.int_taken  = (r_state == TAKE);
      io_seq.in_handler = (r_state == TAKE) || (r_state == HANDLER);
      io_seq.dbg_state  = r_state;
   end

   assign io_seq.int_cause = r_cause;
   assign io_seq.pending   = r_pending;

endmodule

// File: tb/tb_irq_sequencer.sv
// Self-checking bench for irq_sequencer (N_SRC=4) against a behavioural model of the interrupt rules.
module tb_irq_sequencer;

`ifdef IRQ_SEQ_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   localparam int M_IDLE    = 0;
   localparam int M_ARMED   = 1;
   localparam int M_TAKE    = 2;
   localparam int M_HANDLER = 3;

   logic clk;
   logic rst_n;

   irq_sequencer_if #(.N_SRC(4)) bus ();

   irq_sequencer #(.N_SRC(4)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_seq  (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;

   logic [3:0] m_prev;
   logic [3:0] m_pending;
   logic [1:0] m_cause;
   logic [1:0] m_ptr;
   int         m_mode;
   logic [1:0] exp_q[$];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [1:0] pick(input logic [3:0] p, input logic [1:0] start);
      for (int k = 0; k < 4; k++) begin
         int idx;
         idx = (int'(start) + k) % 4;
         if (p[idx]) return 2'(idx);
      end
      return 2'd0;
   endfunction

   task automatic model_reset();
      m_prev    = '0;
      m_pending = '0;
      m_cause   = '0;
      m_ptr     = '0;
      m_mode    = M_IDLE;
      exp_q.delete();
   endtask

   // One rising edge of the spec's rules, using the inputs held stable since the last negedge.
   task automatic model_step();
      logic [3:0] edges;
      logic [1:0] c;
      edges  = bus.irq & ~m_prev;
      m_prev = bus.irq;
      case (m_mode)
         M_IDLE:  if (m_pending != 0 && bus.csr_mie) m_mode = M_ARMED;
         M_ARMED: begin
            if (!bus.csr_mie || m_pending == 0) m_mode = M_IDLE;
            else if (bus.instr_boundary) begin
               c = pick(m_pending, RR ? m_ptr : 2'd0);
               m_cause      = c;
               m_pending[c] = 1'b0;
               m_ptr        = c + 2'd1;
               exp_q.push_back(c);
               m_mode = M_TAKE;
            end
         end
         M_TAKE:    m_mode = M_HANDLER;
         default:   if (bus.mret) m_mode = M_IDLE;
      endcase
      m_pending = m_pending | edges;
   endtask

   task automatic compare_all();
      check_val("int_req",    bus.int_req,    m_mode == M_ARMED);
      check_val("int_taken",  bus.int_taken,  m_mode == M_TAKE);
      check_val("in_handler", bus.in_handler, m_mode >= M_TAKE);
      check_val("int_cause",  bus.int_cause,  m_cause);
      check_val("pending",    bus.pending,    m_pending);
      if (bus.int_taken) begin
         if (exp_q.size() > 0) check_val("take_cause", bus.int_cause, exp_q.pop_front());
         else                  check_val("take_unexpected", bus.int_taken, 0);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle();
      @(posedge clk);
      if (rst_n) model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic pulse_mret();
      bus.mret = 1'b1;
      cycle();
      bus.mret = 1'b0;
   endtask

   task automatic run_until_take(input int budget, output logic [1:0] c);
      bit found;
      found = 1'b0;
      c     = '0;
      for (int i = 0; i < budget && !found; i++) begin
         cycle();
         if (bus.int_taken) begin
            found = 1'b1;
            c     = bus.int_cause;
         end
      end
      check_val("take_timeout", found, 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [1:0] c;
      int         takes;
      rst_n              = 1'b0;
      bus.irq            = '0;
      bus.csr_mie        = 1'b0;
      bus.instr_boundary = 1'b0;
      bus.mret           = 1'b0;

      // IRQ[2] held through reset: first clock sees it as an edge.
      bus.irq = 4'b0100; bus.csr_mie = 1'b1; bus.instr_boundary = 1'b1;
      do_reset();
      cycle();
      check_val("t1_pending", bus.pending, 4'b0100);
      cycle();
      check_val("t1_req", bus.int_req, 1);
      cycle();
      check_val("t1_taken", bus.int_taken, 1);
      check_val("t1_cause", bus.int_cause, 2);
      cycle();
      check_val("t1_handler", bus.in_handler, 1);
      bus.irq = '0;
      repeat (3) cycle();
      pulse_mret();
      cycle();

      // MIE gating.
      bus.csr_mie = 1'b0; bus.instr_boundary = 1'b0;
      bus.irq = 4'b0010; cycle();
      bus.irq = 4'b0000; cycle(); cycle();
      check_val("t2_pending", bus.pending, 4'b0010);
      check_val("t2_req_off", bus.int_req, 0);
      bus.csr_mie = 1'b1; cycle();
      check_val("t2_req_on", bus.int_req, 1);
      bus.csr_mie = 1'b0; cycle();
      check_val("t2_req_drop", bus.int_req, 0);
      check_val("t2_pending_kept", bus.pending, 4'b0010);
      bus.csr_mie = 1'b1; bus.instr_boundary = 1'b1;
      run_until_take(8, c);
      cycle();
      pulse_mret();

      // Two sources rising together; boundary held off for 5 cycles.
      bus.instr_boundary = 1'b0;
      bus.irq = 4'b1010; cycle();
      bus.irq = 4'b0000;
      repeat (4) cycle();
      bus.instr_boundary = 1'b1;
      run_until_take(8, c);
`ifndef IRQ_SEQ_RR_EN
      check_val("t3_first", c, 1);
`endif
      cycle();
      pulse_mret();
      run_until_take(8, c);
`ifndef IRQ_SEQ_RR_EN
      check_val("t3_second", c, 3);
`endif
      cycle();

      // No nesting; MRET coincident with a new edge.
      bus.irq = 4'b0001; cycle();
      bus.irq = 4'b0000;
      repeat (3) cycle();
      check_val("t4_no_nest", bus.int_req, 0);
      bus.irq = 4'b0100; bus.mret = 1'b1;
      cycle();
      bus.mret = 1'b0;
      check_val("t4_pending", bus.pending, 4'b0101);
      run_until_take(8, c);
`ifndef IRQ_SEQ_RR_EN
      check_val("t4_cause", c, 0);
`endif
      cycle();
      pulse_mret();
      run_until_take(8, c);
      cycle();
      bus.irq = 4'b0000;
      pulse_mret();
      cycle();

      // Reset during the TAKE cycle.
      bus.irq = 4'b0001;
      run_until_take(8, c);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("t5_taken_drop", bus.int_taken, 0);
      model_reset();
      compare_all();
      bus.irq = 4'b0000;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) cycle();
      bus.irq = 4'b0001;
      run_until_take(8, c);
      cycle();
      bus.irq = 4'b0000;
      pulse_mret();
      cycle();

      // Level held high produces one take only.
      takes = 0;
      bus.irq = 4'b1000;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (bus.int_taken) takes++;
      end
      check_val("t6_one_take", takes, 1);
      pulse_mret();
      repeat (3) cycle();
      bus.irq = 4'b0000; cycle();
      bus.irq = 4'b1000;
      run_until_take(8, c);
      cycle();
      bus.irq = 4'b0000;
      pulse_mret();

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) < 3) bus.irq = 4'($urandom_range(0, 15));
         bus.csr_mie        = ($urandom_range(0, 7) != 0);
         bus.instr_boundary = 1'($urandom_range(0, 1));
         bus.mret           = ($urandom_range(0, 5) == 0);
         cycle();
      end
      bus.mret = 1'b0;

      check_val("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
